instr_decode_stage: RTL and testbench
=====================================

INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the immediate width; only 32 and 64 are legal.
REQ-002 SHALL have parameter PC_W, default 32, giving the width of the PC passed alongside each instruction.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; every register updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, the reset; asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1 bit, meaning in_instr and in_pc are valid this cycle.
REQ-006 SHALL have port in_ready, output, 1 bit, meaning the stage accepts input this cycle.
REQ-007 SHALL have port in_instr, input, 32 bits, the raw instruction word.
REQ-008 SHALL have port in_pc, input, PC_W bits, the instruction address.
REQ-009 SHALL have port flush, input, 1 bit, which discards all held and incoming instructions.
REQ-010 SHALL have port out_valid, output, 1 bit, meaning all out_* fields are valid.
REQ-011 SHALL have port out_ready, input, 1 bit, meaning the consumer takes the output this cycle.
REQ-012 SHALL have the following field outputs:
- out_op, 7 bits
- out_rd, 5 bits
- out_rs1, 5 bits
- out_rs2, 5 bits
- out_func3, 3 bits
- out_func7, 7 bits
- out_pc, PC_W bits
REQ-013 SHALL have port out_imm, output, XLEN bits, the sign-extended immediate.
REQ-014 SHALL have port out_type, output, 3 bits, the format code: R, I, S, B, U, J or NONE.
REQ-015 SHALL have port out_illegal, output, 1 bit, the unsupported-encoding flag.

Function
REQ-016 SHALL take fields from fixed positions:
- op [6:0]
- rd [11:7]
- func3 [14:12]
- rs1 [19:15]
- rs2 [24:20]
- func7 [31:25]
REQ-017 SHALL classify by opcode:
- 0110011 -> R
- 0010011, 0000011, 1100111, 1110011 -> I
- 0100011 -> S
- 1100011 -> B
- 0110111, 0010111 -> U
- 1101111 -> J
- any other opcode -> NONE with out_illegal=1
REQ-018 SHALL set out_illegal=1 whenever in_instr[1:0]!=2'b11, regardless of opcode.
REQ-019 SHALL build the immediate per the RV32I I/S/B/U/J formats, sign-extended from instr[31] to XLEN; B and J immediates have bit 0 = 0; R and NONE give imm = 0.
REQ-020 SHALL accept an input when in_valid && in_ready; latency from accept to out_valid is exactly 1 cycle.
REQ-021 SHALL register its outputs in a main register backed by a one-entry skid register; in_ready = !skid_full, with no combinational path from out_ready.
REQ-022 SHALL sustain one instruction per cycle when out_ready is held at 1.
REQ-023 SHALL, when out_valid && !out_ready and an input is accepted, store that input in the skid register; the next cycle in_ready = 0.
REQ-024 SHALL, when out_ready is asserted while the skid register is full, move the skid contents to the main register on the next edge; in_ready returns to 1 that same cycle.
REQ-025 SHALL hold all out_* outputs stable while out_valid && !out_ready.
REQ-026 SHALL deliver instructions in acceptance order with no loss or duplication.
REQ-027 SHALL, when flush=1, clear the main and skid valid bits on that edge and discard any input accepted in that cycle.
REQ-028 SHALL drive in_ready = 1 in the cycle after a flush; flush takes priority over all simultaneous events.
REQ-029 SHALL leave field registers unchanged when their valid bit is 0; their values are don't-care to the consumer.

Reset
REQ-030 SHALL, while rst_n=0, immediately force:
- out_valid = 0
- skid valid = 0
- every out_* field = 0
- in_ready = 1
REQ-031 SHALL discard any in-flight instruction when reset is asserted mid-operation; the first edge after rst_n rises accepts input normally.

Structure
REQ-032 SHALL take the opcode constants, the out_type encoding and the format enum from the shared package decode_pkg.
REQ-033 SHALL compute the immediate in a combinational sub-module imm_gen #(XLEN), which is instantiated once, on the input side.

Verification
REQ-034 SHALL cover scenario: in_instr=0xFFF10093 (addi x1,x2,-1), out_ready=1 -> 1 cycle later out_valid=1, rd=1, rs1=2, func3=0, type I, imm=0xFFFFFFFF, illegal=0.
REQ-035 SHALL cover scenario: in_instr=0xFE000EE3 (beq x0,x0,-4) -> type B, imm=0xFFFFFFFC; in_instr=0x123452B7 (lui x5) -> type U, rd=5, imm=0x12345000.
REQ-036 SHALL cover scenario: in_instr=0x00000000 -> out_illegal=1, type NONE, imm=0.
REQ-037 SHALL cover scenario: three back-to-back inputs A, B, C with out_ready=0 -> A in main, B in skid, in_ready=0, C held; then out_ready=1 -> A, B, C emitted on consecutive cycles.
REQ-038 SHALL cover scenario: flush=1 with main and skid full while an input is also accepted -> next cycle out_valid=0 and in_ready=1; none of the three instructions is ever output.
REQ-039 SHALL cover scenario: XLEN=64 with 0xFFF10093 -> imm=0xFFFFFFFFFFFFFFFF; rst_n pulled low while out_valid=1 -> out_valid=0 with no clock edge.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, format codes, decoded bundle.
// Also holds the pure field/format decoder used by the decode stage.
package decode_pkg;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_R    = 3'd1,
        FMT_I    = 3'd2,
        FMT_S    = 3'd3,
        FMT_B    = 3'd4,
        FMT_U    = 3'd5,
        FMT_J    = 3'd6
    } fmt_e;

    typedef struct packed {
        logic [6:0] op;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] func3;
        logic [6:0] func7;
        fmt_e       typ;
        logic       illegal;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] i);
        dec_t d;
        d.op    = i[6:0];
        d.rd    = i[11:7];
        d.func3 = i[14:12];
        d.rs1   = i[19:15];
        d.rs2   = i[24:20];
        d.func7 = i[31:25];
        unique case (1'b1)
            d.op == OP_OP:     d.typ = FMT_R;
            d.op == OP_IMM,
            d.op == OP_LOAD,
            d.op == OP_JALR,
            d.op == OP_SYSTEM: d.typ = FMT_I;
            d.op == OP_STORE:  d.typ = FMT_S;
            d.op == OP_BRANCH: d.typ = FMT_B;
            d.op == OP_LUI,
            d.op == OP_AUIPC:  d.typ = FMT_U;
            d.op == OP_JAL:    d.typ = FMT_J;
            default:           d.typ = FMT_NONE;
        endcase
        // Compressed-space encodings are never supported here.
        d.illegal = (d.typ == FMT_NONE) || (i[1:0] != 2'b11);
        return d;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate builder, sign-extended to XLEN.
// Only instr[31:7] carries immediate bits, so only that slice is taken.
module imm_gen
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     ins,
    input  fmt_e            fmt,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        unique case (fmt)
            FMT_I: imm32 = {{20{ins[31]}}, ins[31:20]};
            FMT_S: imm32 = {{20{ins[31]}}, ins[31:25],
                            ins[11:7]};
            FMT_B: imm32 = {{19{ins[31]}}, ins[31], ins[7],
                            ins[30:25], ins[11:8], 1'b0};
            FMT_U: imm32 = {ins[31:12], 12'b0};
            FMT_J: imm32 = {{11{ins[31]}}, ins[31],
                            ins[19:12], ins[20],
                            ins[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/instr_decode_stage.sv
// Decode stage: field split, format classify, immediate build.
// Registered output backed by a one-entry skid buffer.
module instr_decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [6:0]      out_op,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_func3,
    output logic [6:0]      out_func7,
    output logic [PC_W-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_type,
    output logic            out_illegal
);

    dec_t            in_d;
    logic [XLEN-1:0] in_imm;

    assign in_d = decode(in_instr);

    imm_gen #(.XLEN(XLEN)) u_imm (
        .ins (in_instr[31:7]),
        .fmt (in_d.typ),
        .imm (in_imm)
    );

    logic            main_v;
    dec_t            main_d;
    logic [XLEN-1:0] main_imm;
    logic [PC_W-1:0] main_pc;
    logic            skid_v;
    dec_t            skid_d;
    logic [XLEN-1:0] skid_imm;
    logic [PC_W-1:0] skid_pc;
    logic            acc;

    assign in_ready = !skid_v;
    assign acc      = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_v   <= 1'b0;
            main_d   <= '0;
            main_imm <= '0;
            main_pc  <= '0;
            skid_v   <= 1'b0;
            skid_d   <= '0;
            skid_imm <= '0;
            skid_pc  <= '0;
        end else if (flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (skid_v) begin
            // in_ready is low here, so nothing new can arrive.
            if (out_ready) begin
                main_d   <= skid_d;
                main_imm <= skid_imm;
                main_pc  <= skid_pc;
                skid_v   <= 1'b0;
            end
        end else if (acc) begin
            if (!main_v || out_ready) begin
                main_v   <= 1'b1;
                main_d   <= in_d;
                main_imm <= in_imm;
                main_pc  <= in_pc;
            end else begin
                skid_v   <= 1'b1;
                skid_d   <= in_d;
                skid_imm <= in_imm;
                skid_pc  <= in_pc;
            end
        end else if (out_ready) begin
            main_v <= 1'b0;
        end
    end

    assign out_valid   = main_v;
    assign out_op      = main_d.op;
    assign out_rd      = main_d.rd;
    assign out_rs1     = main_d.rs1;
    assign out_rs2     = main_d.rs2;
    assign out_func3   = main_d.func3;
    assign out_func7   = main_d.func7;
    assign out_type    = main_d.typ;
    assign out_illegal = main_d.illegal;
    assign out_imm     = main_imm;
    assign out_pc      = main_pc;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage (XLEN 32 and 64 instances).
// Inputs change and outputs are sampled 1 time unit after posedge.
module tb_instr_decode_stage;

    localparam logic [2:0] T_NONE = 3'd0;
    localparam logic [2:0] T_R    = 3'd1;
    localparam logic [2:0] T_I    = 3'd2;
    localparam logic [2:0] T_S    = 3'd3;
    localparam logic [2:0] T_B    = 3'd4;
    localparam logic [2:0] T_U    = 3'd5;
    localparam logic [2:0] T_J    = 3'd6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, out_illegal;
    logic [6:0]  out_op, out_func7;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_func3, out_type;
    logic [31:0] out_pc, out_imm;

    logic        w_in_ready, w_out_valid, w_out_illegal;
    logic [6:0]  w_out_op, w_out_func7;
    logic [4:0]  w_out_rd, w_out_rs1, w_out_rs2;
    logic [2:0]  w_out_func3, w_out_type;
    logic [31:0] w_out_pc;
    logic [63:0] w_out_imm;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    instr_decode_stage #(.XLEN(32), .PC_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_rd(out_rd),
        .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_func3(out_func3), .out_func7(out_func7),
        .out_pc(out_pc), .out_imm(out_imm),
        .out_type(out_type), .out_illegal(out_illegal)
    );

    instr_decode_stage #(.XLEN(64), .PC_W(32)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(w_in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .flush(flush),
        .out_valid(w_out_valid), .out_ready(out_ready),
        .out_op(w_out_op), .out_rd(w_out_rd),
        .out_rs1(w_out_rs1), .out_rs2(w_out_rs2),
        .out_func3(w_out_func3), .out_func7(w_out_func7),
        .out_pc(w_out_pc), .out_imm(w_out_imm),
        .out_type(w_out_type), .out_illegal(w_out_illegal)
    );

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins,
                         input logic [31:0] pc);
        in_valid = v;
        in_instr = ins;
        in_pc    = pc;
    endtask

    initial begin
        step();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_rd", 64'(out_rd), 64'd0);
        check("rst_imm", 64'(out_imm), 64'd0);
        check("rst_pc", 64'(out_pc), 64'd0);
        rst_n = 1'b1;

        out_ready = 1'b1;
        drive(1, 32'hFFF10093, 32'h100);
        step();
        check("addi_v", 64'(out_valid), 64'd1);
        check("addi_rd", 64'(out_rd), 64'd1);
        check("addi_rs1", 64'(out_rs1), 64'd2);
        check("addi_f3", 64'(out_func3), 64'd0);
        check("addi_type", 64'(out_type), 64'(T_I));
        check("addi_imm", 64'(out_imm), 64'hFFFFFFFF);
        check("addi_ill", 64'(out_illegal), 64'd0);
        check("addi_pc", 64'(out_pc), 64'h100);
        check("addi_imm64", w_out_imm, 64'hFFFFFFFFFFFFFFFF);
        check("addi_rdy", 64'(in_ready), 64'd1);

        drive(1, 32'hFE000EE3, 32'h104);
        step();
        check("beq_type", 64'(out_type), 64'(T_B));
        check("beq_imm", 64'(out_imm), 64'hFFFFFFFC);
        check("beq_pc", 64'(out_pc), 64'h104);

        drive(1, 32'h123452B7, 32'h108);
        step();
        check("lui_type", 64'(out_type), 64'(T_U));
        check("lui_rd", 64'(out_rd), 64'd5);
        check("lui_imm", 64'(out_imm), 64'h12345000);

        drive(1, 32'h00512423, 32'h10C);
        step();
        check("sw_type", 64'(out_type), 64'(T_S));
        check("sw_imm", 64'(out_imm), 64'd8);
        check("sw_rs2", 64'(out_rs2), 64'd5);
        check("sw_f3", 64'(out_func3), 64'd2);

        drive(1, 32'h402081B3, 32'h110);
        step();
        check("sub_type", 64'(out_type), 64'(T_R));
        check("sub_f7", 64'(out_func7), 64'h20);
        check("sub_imm", 64'(out_imm), 64'd0);
        check("sub_rd", 64'(out_rd), 64'd3);

        drive(1, 32'h001000EF, 32'h114);
        step();
        check("jal_type", 64'(out_type), 64'(T_J));
        check("jal_imm", 64'(out_imm), 64'h800);

        drive(1, 32'h00000000, 32'h118);
        step();
        check("zero_ill", 64'(out_illegal), 64'd1);
        check("zero_type", 64'(out_type), 64'(T_NONE));
        check("zero_imm", 64'(out_imm), 64'd0);

        drive(1, 32'hFFF10091, 32'h11C);
        step();
        check("lo2_ill", 64'(out_illegal), 64'd1);
        check("lo2_type", 64'(out_type), 64'(T_NONE));

        drive(0, 32'h0, 32'h0);
        step();
        check("drain_v", 64'(out_valid), 64'd0);

        out_ready = 1'b0;
        drive(1, 32'hFFF10093, 32'h200);
        step();
        check("bp_a_v", 64'(out_valid), 64'd1);
        check("bp_a_rdy", 64'(in_ready), 64'd1);
        drive(1, 32'h123452B7, 32'h204);
        step();
        check("bp_b_rdy", 64'(in_ready), 64'd0);
        check("bp_b_pc", 64'(out_pc), 64'h200);
        drive(1, 32'hFE000EE3, 32'h208);
        step();
        check("bp_c_rdy", 64'(in_ready), 64'd0);
        check("bp_hold_pc", 64'(out_pc), 64'h200);
        check("bp_hold_imm", 64'(out_imm), 64'hFFFFFFFF);
        out_ready = 1'b1;
        step();
        check("bp_out_b", 64'(out_pc), 64'h204);
        check("bp_b_imm", 64'(out_imm), 64'h12345000);
        check("bp_rdy_back", 64'(in_ready), 64'd1);
        step();
        check("bp_out_c_v", 64'(out_valid), 64'd1);
        check("bp_out_c", 64'(out_pc), 64'h208);
        drive(0, 32'h0, 32'h0);
        step();
        check("bp_done_v", 64'(out_valid), 64'd0);

        out_ready = 1'b0;
        drive(1, 32'hFFF10093, 32'h300);
        step();
        drive(1, 32'h123452B7, 32'h304);
        step();
        check("fl_full", 64'(in_ready), 64'd0);
        drive(1, 32'hFE000EE3, 32'h308);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl_v", 64'(out_valid), 64'd0);
        check("fl_rdy", 64'(in_ready), 64'd1);
        drive(0, 32'h0, 32'h0);
        out_ready = 1'b1;
        step();
        check("fl_v2", 64'(out_valid), 64'd0);

        out_ready = 1'b0;
        drive(1, 32'hFFF10093, 32'h400);
        step();
        drive(1, 32'h123452B7, 32'h404);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(0, 32'h0, 32'h0);
        check("fl_acc_v", 64'(out_valid), 64'd0);
        check("fl_acc_rdy", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        step();
        check("fl_acc_v2", 64'(out_valid), 64'd0);

        out_ready = 1'b0;
        drive(1, 32'h00512423, 32'h500);
        step();
        drive(0, 32'h0, 32'h0);
        check("rm_pre_v", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rm_v", 64'(out_valid), 64'd0);
        check("rm_pc", 64'(out_pc), 64'd0);
        check("rm_rdy", 64'(in_ready), 64'd1);
        check("rm_v64", 64'(w_out_valid), 64'd0);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        drive(1, 32'h123452B7, 32'h600);
        step();
        check("post_rst_v", 64'(out_valid), 64'd1);
        check("post_rst_pc", 64'(out_pc), 64'h600);
        drive(0, 32'h0, 32'h0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
